// File: rtl/riscv_defs.sv
// Shared RISC-V datapath widths and instruction memory geometry.
package riscv_defs;
  localparam int NB_ADDR  = 32;
  localparam int NB_INSTR = 32;
  localparam int NB_BYTE  = 8;
  localparam int MEM_SIZE = 1024;  // instruction memory size in bytes
endpackage

// File: rtl/imem_if.sv
// Instruction memory bus: the CPU drives the byte address, memory answers combinationally.
interface imem_if;
  import riscv_defs::*;

  logic [NB_ADDR-1:0]  imem_pc;
  logic [NB_INSTR-1:0] imem_instruction;

  modport memory (input imem_pc, output imem_instruction);
  modport cpu    (output imem_pc, input imem_instruction);
endinterface

// File: rtl/fetch_fifo.sv
// Small prefetch buffer with wrapping pointers, occupancy count and synchronous flush.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch front end: sequential PC, prefetch buffer toward decode, redirect handling.
module fetch_ctrl
  import riscv_defs::*;
#(
  parameter logic [NB_ADDR-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                 FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  imem_if.cpu                 IMEM_IF,
  input  logic                run,
  input  logic                redirect_valid,
  input  logic [NB_ADDR-1:0]  redirect_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [NB_INSTR-1:0] instr,
  output logic [NB_ADDR-1:0]  instr_pc,
  output logic                misalign_err,
  output logic [31:0]         fetch_count
);
  localparam int               ENTRY_W     = NB_ADDR + NB_INSTR;
  localparam int               INSTR_BYTES = NB_INSTR / NB_BYTE;
  localparam logic [NB_ADDR:0] MEM_LIMIT   = (NB_ADDR + 1)'(MEM_SIZE);

  logic [NB_ADDR-1:0] fetch_pc_reg;
  logic [NB_ADDR-1:0] fetch_pc_next;
  logic [NB_ADDR:0]   pc_plus;
  logic               misalign_err_reg;
  logic [31:0]        fetch_count_reg;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  // A redirect owns the cycle: nothing enters or leaves the buffer alongside the flush.
  assign pop  = !fifo_empty && instr_ready && !redirect_valid;
  assign push = run && !misalign_err_reg && !redirect_valid && (!fifo_full || pop);

  assign pc_plus       = {1'b0, fetch_pc_reg} + (NB_ADDR + 1)'(INSTR_BYTES);
  assign fetch_pc_next = (pc_plus >= MEM_LIMIT) ? '0 : pc_plus[NB_ADDR-1:0];

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   ({fetch_pc_reg, IMEM_IF.imem_instruction}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg     <= RESET_PC;
      misalign_err_reg <= 1'b0;
      fetch_count_reg  <= '0;
    end else if (redirect_valid) begin
      if (redirect_pc[1:0] == 2'b00) begin
        fetch_pc_reg     <= redirect_pc;
        misalign_err_reg <= 1'b0;
      end else begin
        misalign_err_reg <= 1'b1;
      end
    end else begin
      if (push) begin
        fetch_pc_reg <= fetch_pc_next;
      end
      if (pop) begin
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
    end
  end

  assign IMEM_IF.imem_pc   = fetch_pc_reg;
  assign instr_valid       = !fifo_empty;
  assign {instr_pc, instr} = head;
  assign misalign_err      = misalign_err_reg;
  assign fetch_count       = fetch_count_reg;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, checked against a queue model.
module tb_fetch_ctrl;
  import riscv_defs::*;

  localparam int                 DEPTH  = 2;
  localparam logic [NB_ADDR-1:0] RST_PC = '0;
  localparam int                 AW     = $clog2(MEM_SIZE);
  localparam int                 WORDS  = MEM_SIZE / 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                run = 1'b0;
  logic                redirect_valid = 1'b0;
  logic [NB_ADDR-1:0]  redirect_pc = '0;
  logic                instr_ready = 1'b0;
  logic                instr_valid;
  logic [NB_INSTR-1:0] instr;
  logic [NB_ADDR-1:0]  instr_pc;
  logic                misalign_err;
  logic [31:0]         fetch_count;

  logic [NB_INSTR-1:0] mem [WORDS];

  imem_if imem_bus();
  assign imem_bus.imem_instruction = mem[imem_bus.imem_pc[AW-1:2]];

  fetch_ctrl #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .IMEM_IF        (imem_bus),
    .run            (run),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of {pc, instr} entries plus fetch address, error flag, count.
  logic [63:0] q[$];
  logic [31:0] mpc    = RST_PC;
  bit          mmis   = 1'b0;
  logic [31:0] mcount = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] h;
    h = (q.size() != 0) ? q[0] : 64'd0;
    chk("instr_valid", instr_valid, (q.size() != 0));
    chk("instr_pc", instr_pc, h[63:32]);
    chk("instr", instr, h[31:0]);
    chk("misalign_err", misalign_err, mmis);
    chk("fetch_count", fetch_count, mcount);
    chk("imem_pc", imem_bus.imem_pc, mpc);
  endtask

  // Apply the rules to the inputs present before the edge, then compare after it.
  task automatic tick();
    bit          do_pop;
    bit          do_push;
    logic [63:0] entry;
    if (rst) begin
      q.delete();
      mpc    = RST_PC;
      mmis   = 1'b0;
      mcount = '0;
    end else if (redirect_valid) begin
      q.delete();
      if (redirect_pc[1:0] == 2'b00) begin
        mpc  = redirect_pc;
        mmis = 1'b0;
      end else begin
        mmis = 1'b1;
      end
    end else begin
      do_pop  = (q.size() != 0) && instr_ready;
      do_push = run && !mmis && ((q.size() < DEPTH) || do_pop);
      entry   = {mpc, mem[mpc[AW-1:2]]};
      if (do_pop) begin
        $display("pop pc=%08h instr=%08h count=%0d", q[0][63:32], q[0][31:0], mcount + 1);
        void'(q.pop_front());
        mcount = mcount + 1;
      end
      if (do_push) begin
        q.push_back(entry);
        if (longint'(mpc) + 4 >= longint'(MEM_SIZE)) mpc = '0;
        else mpc = mpc + 4;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_redirect(input logic [NB_ADDR-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  logic [31:0] saved_count;

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0000_0013;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("reset_valid", instr_valid, 1'b0);
    chk("reset_imem_pc", imem_bus.imem_pc, RST_PC);

    // Streaming with decode always ready
    rst = 1'b0; run = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_pc", instr_pc, 32'(i * 4));
      chk("stream_instr", instr, 32'h0000_0013);
    end
    tick();
    chk("stream_count", fetch_count, 32'd4);

    // Backpressure fills the buffer and stalls the fetch address
    rst = 1'b1; tick(); rst = 1'b0;
    instr_ready = 1'b0;
    repeat (5) tick();
    chk("stall_imem_pc", imem_bus.imem_pc, 32'd8);
    chk("stall_instr_pc", instr_pc, 32'd0);
    instr_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("release_pc", instr_pc, 32'(i * 4));
    end
    chk("release_count", fetch_count, 32'd3);

    // Redirect while full with a pop pending
    instr_ready = 1'b0;
    repeat (2) tick();
    saved_count = mcount;
    instr_ready = 1'b1;
    do_redirect(32'h40);
    chk("redir_count", fetch_count, saved_count);
    chk("redir_valid0", instr_valid, 1'b0);
    tick();
    chk("redir_valid2", instr_valid, 1'b1);
    chk("redir_pc", instr_pc, 32'h40);

    // Misaligned redirect, then recovery
    do_redirect(32'h42);
    chk("mis_set", misalign_err, 1'b1);
    repeat (3) begin
      tick();
      chk("mis_novalid", instr_valid, 1'b0);
    end
    do_redirect(32'h80);
    chk("mis_clear", misalign_err, 1'b0);
    tick();
    chk("mis_recover_pc", instr_pc, 32'h80);

    // Wrap at the top of memory
    do_redirect(32'(MEM_SIZE - 4));
    tick();
    chk("wrap_last", instr_pc, 32'(MEM_SIZE - 4));
    tick();
    chk("wrap_zero", instr_pc, 32'd0);

    // Reset mid-stream with two buffered entries
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (8) tick();
    instr_ready = 1'b0;
    tick();
    chk("pre_rst_count", fetch_count, 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_imem_pc", imem_bus.imem_pc, RST_PC);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      run         = ($urandom_range(0, 9) < 8);
      instr_ready = ($urandom_range(0, 9) < 7);
      rst         = ($urandom_range(0, 99) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = 32'($urandom_range(WORDS - 3, WORDS - 1) * 4);
      else
        redirect_pc = 32'($urandom_range(0, WORDS - 1) * 4);
      if ($urandom_range(0, 3) == 0)
        redirect_pc[1:0] = 2'($urandom_range(1, 3));
      tick();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, number of prefetch buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port IMEM_IF  interface  imem_if.cpu  drives imem_pc, samples imem_instruction (combinational read, same cycle).
REQ-006 SHALL have port run  input  1  fetch enable; low stops new fetches, buffer still drains.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect strobe.
REQ-008 SHALL have port redirect_pc  input  NB_ADDR  redirect target byte address.
REQ-009 SHALL have port instr_valid  output  1  buffer head holds an instruction.
REQ-010 SHALL have port instr_ready  input  1  decode accepts head this cycle.
REQ-011 SHALL have port instr  output  NB_INSTR  head instruction word.
REQ-012 SHALL have port instr_pc  output  NB_ADDR  byte address of head instruction.
REQ-013 SHALL have port misalign_err  output  1  sticky flag, redirect target not word-aligned.
REQ-014 SHALL have port fetch_count  output  32  count of instructions accepted by decode.

Function
REQ-015 SHALL hold fetch_pc register driving IMEM_IF.imem_pc continuously.
REQ-016 SHALL push {fetch_pc, imem_instruction} into the FIFO when run=1, misalign_err=0, redirect_valid=0 and FIFO not full (or a pop occurs the same cycle), then advance fetch_pc by 4.
REQ-017 SHALL wrap fetch_pc to 0 when fetch_pc+4 >= MEM_SIZE.
REQ-018 SHALL present the FIFO head on instr/instr_pc with instr_valid = FIFO not empty; fetch-to-valid latency one cycle.
REQ-019 SHALL pop the head when instr_valid & instr_ready; instr/instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-020 SHALL, on redirect_valid with redirect_pc[1:0]==0, flush the FIFO, load fetch_pc=redirect_pc, clear misalign_err, and suppress push and pop that cycle; first redirected instr_valid two cycles after the redirect strobe.
REQ-021 SHALL, on redirect_valid with redirect_pc[1:0]!=0, flush the FIFO, set misalign_err, leave fetch_pc unchanged, and stop fetching until an aligned redirect.
REQ-022 SHALL give redirect priority over simultaneous pop and push; a popped-but-flushed instruction is not counted.
REQ-023 SHALL increment fetch_count (mod 2^32) on each accepted pop.
REQ-024 SHALL keep FIFO occupancy counter width clog2(FIFO_DEPTH)+1 with wrapping read/write pointers; never push when full, never pop when empty.

Reset
REQ-025 SHALL on rst=1 set fetch_pc=RESET_PC, FIFO empty (instr_valid=0), instr=0, instr_pc=0, misalign_err=0, fetch_count=0.
REQ-026 SHALL give rst priority over redirect, run and handshake; reset mid-stream discards all buffered instructions.

Structure
REQ-027 SHALL place NB_ADDR, NB_INSTR (32), NB_BYTE, MEM_SIZE in riscv_defs package; no local redefinition.
REQ-028 SHALL place the buffer in one sub-module, fetch_fifo (parameterised width/depth, push/pop/full/empty, synchronous flush).
REQ-029 SHALL keep the imem_if.cpu modport alongside the existing memory modport in the shared interface definition.

Verification
REQ-030 SHALL cover: reset, run=1, instr_ready=1, imem preloaded 0x00000013 at 0..12 -> instr_pc 0,4,8,12 on consecutive cycles from cycle 2, fetch_count=4.
REQ-031 SHALL cover: instr_ready=0 for 5 cycles -> FIFO fills to 2, imem_pc holds at 8, instr_pc stays 0, no loss or duplicate after release.
REQ-032 SHALL cover: redirect_pc=0x40 while FIFO full and instr_ready=1 -> flush, no count increment, instr_pc=0x40 valid 2 cycles later.
REQ-033 SHALL cover: redirect_pc=0x42 -> misalign_err=1, instr_valid=0 thereafter; then redirect_pc=0x80 -> misalign_err=0, instr_pc=0x80.
REQ-034 SHALL cover: fetch_pc=MEM_SIZE-4 -> next instr_pc=0 (wrap).
REQ-035 SHALL cover: rst asserted with 2 entries buffered and fetch_count=7 -> next cycle instr_valid=0, fetch_count=0, imem_pc=RESET_PC.
